// File: rtl/moore_1010.sv
// rtl/moore_1010.sv - Moore FSM that flags each completed 1-0-1-0 on a serial bit stream
//
// Five binary-encoded states track how much of the pattern has been seen.
// det is decoded from the state register alone, so it carries no combinational
// path from in. OVERLAP picks where the search resumes after a match:
// 1 keeps the trailing "10" as a fresh prefix, 0 restarts from scratch.
module moore_1010 #(
  parameter bit OVERLAP = 1'b1
) (
  input  logic clk,
  input  logic rst,
  input  logic in,
  output logic det
);

  typedef enum logic [2:0] {
    S0 = 3'd0,  // idle, no useful prefix
    S1 = 3'd1,  // "1" received
    S2 = 3'd2,  // "10" received
    S3 = 3'd3,  // "101" received
    S4 = 3'd4   // "1010" received, detect state
  } state_t;

  state_t state;
  state_t state_nxt;

  // State register; reset is asynchronous so det drops without waiting for clk.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S0;
    end else begin
      state <= state_nxt;
    end
  end

  // Next-state logic; unused encodings fall through to S0.
  always_comb begin
    state_nxt = S0;
    case (state)
      S0: state_nxt = in ? S1 : S0;
      S1: state_nxt = in ? S1 : S2;
      S2: state_nxt = in ? S3 : S0;
      S3: state_nxt = in ? S1 : S4;
      S4: begin
        if (in) begin
          state_nxt = OVERLAP ? S3 : S1;
        end else begin
          state_nxt = S0;
        end
      end
      default: state_nxt = S0;
    endcase
  end

  // Detect flag decoded purely from the registered state.
  assign det = (state == S4);

endmodule

// File: tb/tb_moore_1010.sv
// tb/tb_moore_1010.sv - self-checking bench for moore_1010 in both detection modes
module tb_moore_1010;

  logic clk;
  logic rst;
  logic in;
  logic det_ov;
  logic det_no;

  int checks;
  int errors;

  // Reference model: last four sampled bits since reset (and, without overlap, since the last match)
  logic [3:0] hist_ov;
  logic [3:0] hist_no;
  logic       exp_ov;
  logic       exp_no;

  typedef struct packed {
    logic in;
    logic ov;
    logic no;
  } vec_t;

  vec_t vecs[$];

  moore_1010 #(.OVERLAP(1'b1)) dut_ov (
    .clk(clk),
    .rst(rst),
    .in (in),
    .det(det_ov)
  );

  moore_1010 #(.OVERLAP(1'b0)) dut_no (
    .clk(clk),
    .rst(rst),
    .in (in),
    .det(det_no)
  );

  // 10 ns clock, rising edges at 5, 15, 25, ...
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string name, input logic act, input logic expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s at %0t: det=%b expected %b", name, $time, act, expv);
    end
  endtask

  task automatic model_reset();
    hist_ov = 4'b0000;
    hist_no = 4'b0000;
    exp_ov  = 1'b0;
    exp_no  = 1'b0;
  endtask

  task automatic model_step(input logic b);
    hist_ov = {hist_ov[2:0], b};
    exp_ov  = (hist_ov == 4'b1010);
    hist_no = {hist_no[2:0], b};
    exp_no  = (hist_no == 4'b1010);
    if (exp_no) hist_no = 4'b0000;
  endtask

  // Drive one bit at the falling edge, let it be sampled, compare 1 ns later.
  task automatic step(input logic b, input string name);
    @(negedge clk);
    in = b;
    @(posedge clk);
    model_step(b);
    #1;
    check({name, "_ov"}, det_ov, exp_ov);
    check({name, "_no"}, det_no, exp_no);
  endtask

  initial begin
    checks = 0;
    errors = 0;
    model_reset();

    // Reset behaviour: rst high 0..10 ns with in=0
    rst = 1'b1;
    in  = 1'b0;
    #2;
    check("rst_async_ov", det_ov, 1'b0);
    check("rst_async_no", det_no, 1'b0);
    #4;
    check("rst_hold_ov", det_ov, 1'b0);
    check("rst_hold_no", det_no, 1'b0);
    checks++;
    if (3'(dut_ov.state) !== 3'd0) begin
      errors++;
      $display("FAIL rst_state at %0t: state=%0d expected 0", $time, 3'(dut_ov.state));
    end
    #4;
    rst = 1'b0;
    @(posedge clk);
    model_step(1'b0);
    #1;
    check("post_rst_ov", det_ov, 1'b0);
    check("post_rst_no", det_no, 1'b0);

    // Table: basic match / overlap stream 1010100, then 1010, then near-misses
    vecs.push_back('{1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1});
    vecs.push_back('{1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b1, 1'b1});
    vecs.push_back('{1'b0, 1'b0, 1'b0});
    // 1100
    vecs.push_back('{1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0});
    // 1011
    vecs.push_back('{1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b0, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0});
    vecs.push_back('{1'b1, 1'b0, 1'b0});
    // 0000 1111
    for (int i = 0; i < 4; i++) vecs.push_back('{1'b0, 1'b0, 1'b0});
    for (int i = 0; i < 4; i++) vecs.push_back('{1'b1, 1'b0, 1'b0});

    for (int i = 0; i < vecs.size(); i++) begin
      step(vecs[i].in, $sformatf("model[%0d]", i));
      check($sformatf("tbl_ov[%0d]", i), det_ov, vecs[i].ov);
      check($sformatf("tbl_no[%0d]", i), det_no, vecs[i].no);
    end

    // Async reset mid-match: 101, reset pulse between edges, then 0
    step(1'b0, "pre0");
    step(1'b1, "mid1");
    step(1'b0, "mid2");
    step(1'b1, "mid3");
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    rst = 1'b0;
    step(1'b0, "after_rst");
    check("prefix_drop_ov", det_ov, 1'b0);
    check("prefix_drop_no", det_no, 1'b0);

    // Reset while det=1: det must fall before the next rising edge
    step(1'b1, "d1");
    step(1'b0, "d2");
    step(1'b1, "d3");
    step(1'b0, "d4");
    check("det_hi_ov", det_ov, 1'b1);
    check("det_hi_no", det_no, 1'b1);
    #2;
    rst = 1'b1;
    model_reset();
    #1;
    check("det_drop_ov", det_ov, 1'b0);
    check("det_drop_no", det_no, 1'b0);
    @(negedge clk);
    rst = 1'b0;

    // Randomized stream with occasional resets against the reference model
    for (int i = 0; i < 600; i++) begin
      logic r;
      logic b;
      @(negedge clk);
      r   = ($urandom % 60) == 0;
      b   = 1'($urandom);
      rst = r;
      in  = b;
      if (r) model_reset();
      @(posedge clk);
      if (!r) model_step(b);
      #1;
      check($sformatf("rand_ov[%0d]", i), det_ov, exp_ov);
      check($sformatf("rand_no[%0d]", i), det_no, exp_no);
    end
    @(negedge clk);
    rst = 1'b0;

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
